// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler: paces ADC conversions per audio frame, publishes
// each result as a sample, and forwards one channel's sample to the DAC.
// Port names are kept as in the original design.
module adc_frame_scheduler #(
    parameter int unsigned DIV     = 1042,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  chan_mask,
    input  logic [2:0]  dac_chan,
    input  logic        err_clr,
    output logic        adc_start,
    output logic [2:0]  adc_chan,
    input  logic        adc_done,
    input  logic [11:0] adc_data,
    output logic        smp_valid,
    output logic [2:0]  smp_chan,
    output logic [11:0] smp_data,
    output logic        dac_valid,
    output logic [11:0] dac_data,
    input  logic        dac_ready,
    output logic        overrun,
    output logic        timeout_err
);

    localparam logic [15:0] CNT_LAST  = 16'(DIV - 1);
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2,
        DAC  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  mask_q, mask_d;
    logic        hit_q, hit_d;
    logic [7:0]  wait_q, wait_d;
    logic [2:0]  chan_q, chan_d;
    logic        smp_valid_q, smp_valid_d;
    logic [2:0]  smp_chan_q, smp_chan_d;
    logic [11:0] smp_data_q, smp_data_d;
    logic [11:0] dac_data_q, dac_data_d;
    logic        ovr_q, ovr_d;
    logic        tmo_q, tmo_d;
    logic        tick;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (m[i] && !found) begin
                idx   = i[2:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Frame timer: free-runs while enabled, held at zero otherwise.
    always_comb begin
        tick  = enable && (cnt_q == CNT_LAST);
        cnt_d = (!enable || tick) ? '0 : cnt_q + 16'd1;
    end

    // Next-state and datapath updates for the scan/wait/dac sequence.
    // adc_chan is loaded on entry to SCAN so it is already valid while
    // adc_start is high.
    always_comb begin
        logic       finish;
        logic       tmo_set;
        logic [7:0] bit_sel;
        state_d     = state_q;
        mask_d      = mask_q;
        hit_d       = hit_q;
        wait_d      = wait_q;
        chan_d      = chan_q;
        smp_valid_d = 1'b0;
        smp_chan_d  = smp_chan_q;
        smp_data_d  = smp_data_q;
        dac_data_d  = dac_data_q;
        finish      = 1'b0;
        tmo_set     = 1'b0;
        bit_sel     = 8'd1 << chan_q;

        case (state_q)
            IDLE: begin
                if (tick && (chan_mask != '0)) begin
                    mask_d  = chan_mask;
                    hit_d   = 1'b0;
                    chan_d  = lowest(chan_mask);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wait_d = wait_q + 8'd1;
                if (adc_done) begin
                    smp_valid_d = 1'b1;
                    smp_chan_d  = chan_q;
                    smp_data_d  = adc_data;
                    mask_d      = mask_q & ~bit_sel;
                    if (chan_q == dac_chan) begin
                        dac_data_d = adc_data;
                        hit_d      = 1'b1;
                    end
                    finish = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    tmo_set = 1'b1;
                    mask_d  = mask_q & ~bit_sel;
                    finish  = 1'b1;
                end
                if (finish) begin
                    if (mask_d != '0) begin
                        chan_d  = lowest(mask_d);
                        state_d = SCAN;
                    end else if (hit_d) begin
                        state_d = DAC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DAC: begin
                if (dac_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sticky flags: a new set event wins over a simultaneous clear.
        ovr_d = (ovr_q & ~err_clr) | (tick && (state_q != IDLE));
        tmo_d = (tmo_q & ~err_clr) | tmo_set;
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            hit_q       <= 1'b0;
            wait_q      <= '0;
            chan_q      <= '0;
            smp_valid_q <= 1'b0;
            smp_chan_q  <= '0;
            smp_data_q  <= '0;
            dac_data_q  <= '0;
            ovr_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            hit_q       <= hit_d;
            wait_q      <= wait_d;
            chan_q      <= chan_d;
            smp_valid_q <= smp_valid_d;
            smp_chan_q  <= smp_chan_d;
            smp_data_q  <= smp_data_d;
            dac_data_q  <= dac_data_d;
            ovr_q       <= ovr_d;
            tmo_q       <= tmo_d;
        end
    end

    assign adc_start   = (state_q == SCAN);
    assign dac_valid   = (state_q == DAC);
    assign adc_chan    = chan_q;
    assign smp_valid   = smp_valid_q;
    assign smp_chan    = smp_chan_q;
    assign smp_data    = smp_data_q;
    assign dac_data    = dac_data_q;
    assign overrun     = ovr_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Directed bench for adc_frame_scheduler with DIV=40, TIMEOUT=8.
module tb_adc_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  chan_mask;
    logic [2:0]  dac_chan;
    logic        err_clr;
    logic        adc_start;
    logic [2:0]  adc_chan;
    logic        adc_done;
    logic [11:0] adc_data;
    logic        smp_valid;
    logic [2:0]  smp_chan;
    logic [11:0] smp_data;
    logic        dac_valid;
    logic [11:0] dac_data;
    logic        dac_ready;
    logic        overrun;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel, r1, r2;
    logic adc_answer;
    int   adc_cd;
    logic [2:0] adc_ch;

    logic [2:0]  start_ch[$];
    int          start_cy[$];
    logic [14:0] smp_ev[$];
    int          smp_cy[$];
    int          dac_cy[$];
    logic [11:0] dac_dat[$];

    adc_frame_scheduler #(.DIV(40), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
        .dac_chan(dac_chan), .err_clr(err_clr), .adc_start(adc_start),
        .adc_chan(adc_chan), .adc_done(adc_done), .adc_data(adc_data),
        .smp_valid(smp_valid), .smp_chan(smp_chan), .smp_data(smp_data),
        .dac_valid(dac_valid), .dac_data(dac_data), .dac_ready(dac_ready),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] adc_value(input logic [2:0] ch);
        case (ch)
            3'd0:    return 12'h123;
            3'd2:    return 12'hABC;
            3'd7:    return 12'h7E5;
            default: return {9'h080, ch};
        endcase
    endfunction

    // ADC model: answers 3 cycles after a sampled adc_start.
    always @(negedge clk) begin
        adc_done = 1'b0;
        if (reset) begin
            adc_cd = 0;
        end else begin
            if (adc_cd != 0) begin
                adc_cd = adc_cd - 1;
                if (adc_cd == 0) begin
                    adc_done = 1'b1;
                    adc_data = adc_value(adc_ch);
                end
            end
            if (adc_start && adc_answer) begin
                adc_cd = 3;
                adc_ch = adc_chan;
            end
        end
    end

    // Event recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (adc_start) begin
                start_ch.push_back(adc_chan);
                start_cy.push_back(cyc);
            end
            if (smp_valid) begin
                smp_ev.push_back({smp_chan, smp_data});
                smp_cy.push_back(cyc);
            end
            if (dac_valid) begin
                dac_cy.push_back(cyc);
                dac_dat.push_back(dac_data);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        start_ch.delete(); start_cy.delete();
        smp_ev.delete();   smp_cy.delete();
        dac_cy.delete();   dac_dat.delete();
    endtask

    function automatic logic [63:0] all_out();
        return {29'd0, adc_start, adc_chan, smp_valid, smp_chan, smp_data,
                dac_valid, dac_data, overrun, timeout_err};
    endfunction

    initial begin
        logic all_abc;
        reset = 1'b1; enable = 1'b0; chan_mask = '0; dac_chan = '0;
        err_clr = 1'b0; dac_ready = 1'b0; adc_answer = 1'b0;
        adc_done = 1'b0; adc_data = '0; adc_cd = 0; adc_ch = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_out(), 64'd0);

        // Two normal frames: mask 0x05, DAC on channel 2.
        reset = 1'b0; enable = 1'b1; chan_mask = 8'h05; dac_chan = 3'd2;
        dac_ready = 1'b1; adc_answer = 1'b1;
        rel = cyc;
        clear_log();
        goto(rel + 95);
        check("s1_start_n", start_ch.size(), 4);
        check("s1_start0",  {start_ch[0], 32'(start_cy[0] - rel)}, {3'd0, 32'd40});
        check("s1_start1",  {start_ch[1], 32'(start_cy[1] - rel)}, {3'd2, 32'd44});
        check("s1_start2",  {start_ch[2], 32'(start_cy[2] - rel)}, {3'd0, 32'd80});
        check("s1_smp_n",   smp_ev.size(), 4);
        check("s1_smp0",    {smp_ev[0], 32'(smp_cy[0] - rel)}, {15'h0123, 32'd44});
        check("s1_smp1",    {smp_ev[1], 32'(smp_cy[1] - rel)}, {15'h2ABC, 32'd48});
        check("s1_smp3",    smp_ev[3], 15'h2ABC);
        check("s1_dac_n",   dac_cy.size(), 2);
        check("s1_dac0",    {dac_dat[0], 32'(dac_cy[0] - rel)}, {12'hABC, 32'd48});
        check("s1_dac1",    32'(dac_cy[1] - rel), 32'd88);
        check("s1_flags",   {overrun, timeout_err}, 2'b00);

        // Silent ADC on channel 1: timeout, nothing published, retry next frame.
        chan_mask = 8'h02; adc_answer = 1'b0;
        clear_log();
        goto(rel + 127);
        check("s2_start",   {start_ch[0], 32'(start_cy[0] - rel)}, {3'd1, 32'd120});
        check("s2_tmo_early", timeout_err, 1'b0);
        goto(rel + 129);
        check("s2_tmo_set", timeout_err, 1'b1);
        goto(rel + 161);
        check("s2_no_smp",  smp_ev.size(), 0);
        check("s2_no_dac",  dac_cy.size(), 0);
        check("s2_retry",   {32'(start_ch.size()), start_ch[1], 32'(start_cy[1] - rel)},
                            {32'd2, 3'd1, 32'd160});
        goto(rel + 170);
        err_clr = 1'b1;
        goto(rel + 171);
        err_clr = 1'b0;
        check("s2_clear",   {overrun, timeout_err}, 2'b00);

        // DAC stall for 60 cycles.
        chan_mask = 8'h05; adc_answer = 1'b1; dac_ready = 1'b0;
        clear_log();
        goto(rel + 239);
        check("s3_ovr_before", overrun, 1'b0);
        goto(rel + 240);
        check("s3_ovr_set", overrun, 1'b1);
        goto(rel + 268);
        all_abc = 1'b1;
        foreach (dac_dat[i]) if (dac_dat[i] !== 12'hABC) all_abc = 1'b0;
        check("s3_dac_cycles", dac_cy.size(), 60);
        check("s3_dac_stable", {all_abc, 32'(dac_cy[0] - rel)}, {1'b1, 32'd208});
        check("s3_valid_hold", {dac_valid, dac_data}, {1'b1, 12'hABC});
        dac_ready = 1'b1;
        goto(rel + 269);
        check("s3_valid_drop", dac_valid, 1'b0);
        goto(rel + 270);
        dac_ready = 1'b0;

        // err_clr against a coincident overrun tick, then err_clr alone.
        goto(rel + 300);
        err_clr = 1'b1;
        goto(rel + 301);
        err_clr = 1'b0;
        check("s4_ovr_clr", {overrun, timeout_err, dac_valid}, 3'b001);
        goto(rel + 319);
        err_clr = 1'b1;
        goto(rel + 320);
        err_clr = 1'b0;
        check("s4_set_wins", overrun, 1'b1);
        dac_ready = 1'b1;
        goto(rel + 322);
        err_clr = 1'b1;
        goto(rel + 323);
        err_clr = 1'b0;
        check("s4_clr_alone", {overrun, timeout_err}, 2'b00);

        // Empty mask for three frames, then channel 7 only.
        chan_mask = 8'h00;
        clear_log();
        goto(rel + 440);
        chan_mask = 8'h80;
        goto(rel + 470);
        check("s5_no_start", {32'(start_ch.size()), overrun}, {32'd0, 1'b0});
        goto(rel + 481);
        check("s5_ch7", {32'(start_ch.size()), start_ch[0], 32'(start_cy[0] - rel)},
                        {32'd1, 3'd7, 32'd480});

        // Reset while waiting for a conversion.
        goto(rel + 482);
        check("s6_in_wait", {adc_start, adc_chan, dac_data}, {1'b0, 3'd7, 12'hABC});
        reset = 1'b1;
        #1;
        check("s6_reset_wait", all_out(), 64'd0);
        goto(cyc + 3);
        reset = 1'b0; chan_mask = 8'h04; dac_chan = 3'd2; dac_ready = 1'b0;
        r1 = cyc;
        clear_log();
        goto(r1 + 46);
        check("s6_in_dac", {dac_valid, dac_data}, {1'b1, 12'hABC});
        reset = 1'b1;
        #1;
        check("s6_reset_dac", all_out(), 64'd0);
        goto(cyc + 2);
        reset = 1'b0; dac_ready = 1'b1;
        r2 = cyc;
        clear_log();
        goto(r2 + 39);
        check("s6_no_early_start", start_ch.size(), 0);
        goto(r2 + 41);
        check("s6_first_start", {32'(start_ch.size()), start_ch[0], 32'(start_cy[0] - r2)},
                                {32'd1, 3'd2, 32'd40});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
